// File: rtl/stepper_ramp_controller_pkg.sv
// Shared types, default parameter values and arithmetic helpers for the stepper ramp controller.
package stepper_ramp_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } chan_state_t;

    localparam int             DEF_N_CH      = 2;
    localparam int             DEF_SPEED_W   = 10;
    localparam int             DEF_MAX_SPEED = 511;
    localparam int             DEF_ACC_W     = 20;
    localparam int             DEF_ACCEL     = 4;
    localparam int             DEF_RAMP_DIV  = 1000;
    localparam int             DEF_STEP_HI   = 200;
    localparam int             DEF_DIR_SETUP = 100;
    localparam int             DEF_POS_W     = 32;
    localparam logic [2:0]     DEF_MICROSTEP = 3'b000;

    function automatic int abs_int(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Symmetric clip so the most-negative code cannot exceed the positive limit.
    function automatic int clip_speed(input int v, input int max_s);
        if (v > max_s)  return max_s;
        if (v < -max_s) return -max_s;
        return v;
    endfunction

endpackage

// File: rtl/stepper_ramp_controller_if.sv
// Speed command port: all channel targets travel together on one valid/ready beat.
interface stepper_ramp_controller_if #(
    parameter int N_CH    = 2,
    parameter int SPEED_W = 10
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [N_CH-1:0][SPEED_W-1:0]  cmd_speed;

    modport master (output cmd_valid, output cmd_speed, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_speed, output cmd_ready);
endinterface

// File: rtl/stepper_ramp_controller_channel.sv
// One motor channel: direction FSM, bounded-acceleration ramp, NCO step generator,
// fixed-width pulse stretcher and signed position counter.
module stepper_ramp_controller_channel
    import stepper_ramp_controller_pkg::*;
#(
    parameter int SPEED_W   = DEF_SPEED_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int ACCEL     = DEF_ACCEL,
    parameter int STEP_HI   = DEF_STEP_HI,
    parameter int DIR_SETUP = DEF_DIR_SETUP,
    parameter int POS_W     = DEF_POS_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      tick_i,
    input  logic signed [SPEED_W-1:0] target_i,
    output logic                      step_o,
    output logic                      dir_o,
    output logic [POS_W-1:0]          position_o,
    output logic                      busy_o
);
    localparam int SU_W = $clog2(DIR_SETUP + 1);
    localparam int HI_W = $clog2(STEP_HI + 1);
    localparam logic [SPEED_W-1:0] ACCEL_M = SPEED_W'(ACCEL);

    chan_state_t          state_q, state_d;
    logic [SPEED_W-1:0]   cur_mag_q, cur_mag_d, ramp_mag, tgt_mag;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W:0]       acc_sum;
    logic                 dir_q, dir_d, step_q, step_d;
    logic [SU_W-1:0]      setup_q, setup_d;
    logic [HI_W-1:0]      hi_q, hi_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 tgt_nz, tgt_fwd;

    assign tgt_nz  = (target_i != '0);
    assign tgt_fwd = ~target_i[SPEED_W-1];
    assign tgt_mag = SPEED_W'(abs_int(int'(target_i)));
    assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(cur_mag_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_mag_q <= '0;
            acc_q     <= '0;
            dir_q     <= 1'b0;
            setup_q   <= '0;
            step_q    <= 1'b0;
            hi_q      <= '0;
            pos_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_mag_q <= cur_mag_d;
            acc_q     <= acc_d;
            dir_q     <= dir_d;
            setup_q   <= setup_d;
            step_q    <= step_d;
            hi_q      <= hi_d;
            pos_q     <= pos_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_mag_d = cur_mag_q;
        acc_d     = acc_q;
        dir_d     = dir_q;
        setup_d   = setup_q;
        step_d    = step_q;
        hi_d      = hi_q;
        pos_d     = pos_q;

        // Opposite-sign or zero targets always decelerate first, so reversal passes through 0.
        if (tgt_nz && (tgt_fwd == dir_q)) begin
            if (cur_mag_q < tgt_mag)
                ramp_mag = (tgt_mag - cur_mag_q > ACCEL_M) ? cur_mag_q + ACCEL_M : tgt_mag;
            else if (cur_mag_q > tgt_mag)
                ramp_mag = (cur_mag_q - tgt_mag > ACCEL_M) ? cur_mag_q - ACCEL_M : tgt_mag;
            else
                ramp_mag = cur_mag_q;
        end else begin
            ramp_mag = (cur_mag_q > ACCEL_M) ? cur_mag_q - ACCEL_M : '0;
        end

        case (state_q)
            ST_IDLE: begin
                cur_mag_d = '0;
                acc_d     = '0;
                // Hold direction until a trailing pulse has finished.
                if (tgt_nz && !step_q) begin
                    dir_d = tgt_fwd;
                    if (tgt_fwd != dir_q) begin
                        setup_d = SU_W'(DIR_SETUP);
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_SETUP: begin
                if (!tgt_nz)
                    state_d = ST_IDLE;
                else if (setup_q == '0)
                    state_d = ST_RUN;
                else
                    setup_d = setup_q - SU_W'(1);
            end
            ST_RUN: begin
                acc_d = acc_sum[ACC_W-1:0];
                if (tick_i)
                    cur_mag_d = ramp_mag;
                if ((cur_mag_q == '0) && (!tgt_nz || (tgt_fwd != dir_q)))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (step_q) begin
            if (hi_q == '0)
                step_d = 1'b0;
            else
                hi_d = hi_q - HI_W'(1);
        end else if ((state_q == ST_RUN) && acc_sum[ACC_W]) begin
            step_d = 1'b1;
            hi_d   = HI_W'(STEP_HI - 1);
            pos_d  = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end
    end

    assign step_o     = step_q;
    assign dir_o      = dir_q;
    assign position_o = pos_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: rtl/stepper_ramp_controller.sv
// N-channel stepper controller: command capture with clipping, shared ramp divider,
// driver enable and microstep tie-off around N independent channel engines.
module stepper_ramp_controller
    import stepper_ramp_controller_pkg::*;
#(
    parameter int         N_CH      = DEF_N_CH,
    parameter int         SPEED_W   = DEF_SPEED_W,
    parameter int         MAX_SPEED = DEF_MAX_SPEED,
    parameter int         ACC_W     = DEF_ACC_W,
    parameter int         ACCEL     = DEF_ACCEL,
    parameter int         RAMP_DIV  = DEF_RAMP_DIV,
    parameter int         STEP_HI   = DEF_STEP_HI,
    parameter int         DIR_SETUP = DEF_DIR_SETUP,
    parameter int         POS_W     = DEF_POS_W,
    parameter logic [2:0] MICROSTEP = DEF_MICROSTEP
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        run_en,
    stepper_ramp_controller_if.slave    cmd,
    output logic [N_CH-1:0]             step,
    output logic [N_CH-1:0]             dir,
    output logic                        en_n,
    output logic [2:0]                  ms,
    output logic [N_CH-1:0][POS_W-1:0]  position,
    output logic [N_CH-1:0]             busy
);
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick, cmd_ready, cmd_fire, en_n_q, en_n_d;

    assign cmd_ready     = ~reset;
    assign cmd.cmd_ready = cmd_ready;
    assign cmd_fire      = cmd.cmd_valid & cmd_ready;

    assign tick  = (div_q == DIV_W'(RAMP_DIV - 1));
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    assign en_n_d = ~(run_en | (|busy));

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q  <= '0;
            en_n_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            en_n_q <= en_n_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic signed [SPEED_W-1:0] target_q, target_d, eff_target;

            assign target_d   = SPEED_W'(clip_speed(int'($signed(cmd.cmd_speed[gi])), MAX_SPEED));
            assign eff_target = run_en ? target_q : '0;

            always_ff @(posedge clock) begin
                if (reset)
                    target_q <= '0;
                else if (cmd_fire)
                    target_q <= target_d;
            end

            stepper_ramp_controller_channel #(
                .SPEED_W   (SPEED_W),
                .ACC_W     (ACC_W),
                .ACCEL     (ACCEL),
                .STEP_HI   (STEP_HI),
                .DIR_SETUP (DIR_SETUP),
                .POS_W     (POS_W)
            ) u_channel (
                .clock      (clock),
                .reset      (reset),
                .tick_i     (tick),
                .target_i   (eff_target),
                .step_o     (step[gi]),
                .dir_o      (dir[gi]),
                .position_o (position[gi]),
                .busy_o     (busy[gi])
            );
        end
    endgenerate

    assign en_n = en_n_q;
    assign ms   = MICROSTEP;

endmodule

// File: tb/tb_stepper_ramp_controller.sv
// Directed bench for stepper_ramp_controller, scaled-down timing so full ramps fit in a short run.
module tb_stepper_ramp_controller;

    localparam int         N_CH      = 2;
    localparam int         SPEED_W   = 10;
    localparam int         MAX_SPEED = 200;
    localparam int         ACC_W     = 12;
    localparam int         ACCEL     = 4;
    localparam int         RAMP_DIV  = 20;
    localparam int         STEP_HI   = 4;
    localparam int         DIR_SETUP = 10;
    localparam int         POS_W     = 32;
    localparam logic [2:0] MICROSTEP = 3'b101;

    logic                        clock, reset, run_en;
    logic [N_CH-1:0]             step, dir, busy;
    logic                        en_n;
    logic [2:0]                  ms;
    logic [N_CH-1:0][POS_W-1:0]  position;

    stepper_ramp_controller_if #(.N_CH(N_CH), .SPEED_W(SPEED_W)) cmd_if ();

    stepper_ramp_controller #(
        .N_CH(N_CH), .SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED), .ACC_W(ACC_W),
        .ACCEL(ACCEL), .RAMP_DIV(RAMP_DIV), .STEP_HI(STEP_HI),
        .DIR_SETUP(DIR_SETUP), .POS_W(POS_W), .MICROSTEP(MICROSTEP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .run_en   (run_en),
        .cmd      (cmd_if.slave),
        .step     (step),
        .dir      (dir),
        .en_n     (en_n),
        .ms       (ms),
        .position (position),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitor state, written only by the monitor process.
    int         cyc = 0;
    int         rises[2]     = '{0, 0};
    int         exp_pos[2]   = '{0, 0};
    int         last_rise[2] = '{-1, -1};
    int         period[2]    = '{0, 0};
    int         hi_len[2]    = '{0, 0};
    int         hi_min       = 1000000;
    int         hi_max       = 0;
    int         dir_viol     = 0;
    logic [1:0] prev_step    = 2'b00;
    logic [1:0] prev_dir     = 2'b00;

    // Measurement results, written only by the main process.
    int mn_p[2];
    int mx_p[2];

    always @(negedge clock) begin
        cyc = cyc + 1;
        for (int ch = 0; ch < 2; ch++) begin
            if (reset) begin
                exp_pos[ch] = 0;
                hi_len[ch]  = 0;
            end else begin
                if (step[ch] && !prev_step[ch]) begin
                    rises[ch]   = rises[ch] + 1;
                    exp_pos[ch] = exp_pos[ch] + (dir[ch] ? 1 : -1);
                    period[ch]  = (last_rise[ch] >= 0) ? cyc - last_rise[ch] : 0;
                    last_rise[ch] = cyc;
                    hi_len[ch]  = 1;
                end else if (step[ch]) begin
                    hi_len[ch] = hi_len[ch] + 1;
                    if (dir[ch] != prev_dir[ch]) dir_viol = dir_viol + 1;
                end else if (prev_step[ch]) begin
                    if (hi_len[ch] < hi_min) hi_min = hi_len[ch];
                    if (hi_len[ch] > hi_max) hi_max = hi_len[ch];
                end
            end
        end
        prev_step = step;
        prev_dir  = dir;
    end

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [SPEED_W-1:0] s0, input logic [SPEED_W-1:0] s1);
        check("cmd_ready", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid    = 1'b1;
        cmd_if.cmd_speed[0] = s0;
        cmd_if.cmd_speed[1] = s1;
        cyc_wait(1);
        cmd_if.cmd_valid = 1'b0;
        $display("cmd at cycle %0d: speed0=%0d speed1=%0d run_en=%0b",
                 cyc, $signed(s0), $signed(s1), run_en);
    endtask

    task automatic wait_rises(input int ch, input int n, input int limit, input string tag);
        int goal;
        int k;
        goal = rises[ch] + n;
        k = 0;
        while (rises[ch] < goal && k < limit) begin
            cyc_wait(1);
            k++;
        end
        check(tag, rises[ch] >= goal, 1);
    endtask

    task automatic measure(input int ncyc);
        int seen[2];
        for (int ch = 0; ch < 2; ch++) begin
            mn_p[ch] = 1000000;
            mx_p[ch] = 0;
            seen[ch] = rises[ch];
        end
        repeat (ncyc) begin
            cyc_wait(1);
            for (int ch = 0; ch < 2; ch++) begin
                if (rises[ch] != seen[ch]) begin
                    seen[ch] = rises[ch];
                    if (period[ch] < mn_p[ch]) mn_p[ch] = period[ch];
                    if (period[ch] > mx_p[ch]) mx_p[ch] = period[ch];
                end
            end
        end
    endtask

    int cyc_mark, k, dur, viol, pos_mark;

    initial begin
        reset = 1'b1;
        run_en = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_speed = '0;
        cyc_wait(3);

        // Reset state
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_en_n", en_n, 1);
        check("rst_busy", busy, 0);
        check("rst_pos0", position[0], 0);
        check("rst_pos1", position[1], 0);
        check("rst_cmd_ready", cmd_if.cmd_ready, 0);
        check("ms_tie", ms, 3'b101);
        reset = 1'b0;
        cyc_wait(2);
        check("idle_en_n", en_n, 1);

        // Test 1: start from rest toward +100 on ch0 only
        run_en = 1'b1;
        send_cmd(10'd100, 10'd0);
        k = 0;
        while (!dir[0] && k < 5) begin cyc_wait(1); k++; end
        check("t1_dir", dir[0], 1);
        cyc_mark = cyc;
        check("t1_busy", busy, 2'b01);
        check("t1_en_n", en_n, 0);
        wait_rises(0, 1, 2000, "t1_first_step");
        check("t1_setup_gap", (last_rise[0] - cyc_mark) >= DIR_SETUP, 1);
        cyc_wait(300);
        measure(1150);
        check("t1_period_min", mn_p[0], 40);
        check("t1_period_max", mx_p[0], 41);
        check("t1_ch1_steps", rises[1], 0);
        check("t1_pos0", $signed(position[0]), exp_pos[0]);

        // Test 2: reverse to -100
        send_cmd(-10'sd100, 10'd0);
        k = 0;
        while (dir[0] && k < 2000) begin cyc_wait(1); k++; end
        check("t2_dir", dir[0], 0);
        cyc_mark = cyc;
        pos_mark = $signed(position[0]);
        check("t2_pos_at_rev", pos_mark, exp_pos[0]);
        wait_rises(0, 1, 2000, "t2_first_rev_step");
        check("t2_setup_gap", (last_rise[0] - cyc_mark) >= DIR_SETUP, 1);
        cyc_wait(300);
        measure(1150);
        check("t2_period_min", mn_p[0], 40);
        check("t2_period_max", mx_p[0], 41);
        check("t2_pos_dec", $signed(position[0]) < pos_mark, 1);
        check("t2_pos0", $signed(position[0]), exp_pos[0]);

        // Test 3: out-of-range targets clip to +/-MAX_SPEED (period 20/21 instead of 8)
        send_cmd(10'd511, 10'h200);
        cyc_wait(1800);
        measure(600);
        check("t3_p0_min", mn_p[0], 20);
        check("t3_p0_max", mx_p[0], 21);
        check("t3_p1_min", mn_p[1], 20);
        check("t3_p1_max", mx_p[1], 21);
        check("t3_dir", dir, 2'b01);

        // Test 4: controlled stop from 200 takes 50 ramp ticks
        run_en = 1'b0;
        cyc_mark = cyc;
        k = 0;
        while (busy != 2'b00 && k < 1500) begin cyc_wait(1); k++; end
        dur = cyc - cyc_mark;
        check("t4_idle", busy, 0);
        check("t4_ramp_lo", dur >= 49 * RAMP_DIV, 1);
        check("t4_ramp_hi", dur <= 50 * RAMP_DIV + 3, 1);
        check("t4_en_n_lag", en_n, 0);
        cyc_wait(1);
        check("t4_en_n", en_n, 1);
        cyc_wait(10);
        check("t4_pos0", $signed(position[0]), exp_pos[0]);
        check("t4_pos1", $signed(position[1]), exp_pos[1]);

        // Test 5: retarget +40 -> +8 mid-ramp never returns to 0
        run_en = 1'b1;
        send_cmd(10'd40, 10'd0);
        cyc_wait(5 * RAMP_DIV + 10);
        send_cmd(10'd8, 10'd0);
        viol = 0;
        repeat (1500) begin
            cyc_wait(1);
            if (!busy[0] || !dir[0]) viol++;
        end
        check("t5_no_stop", viol, 0);
        measure(1200);
        check("t5_period_min", mn_p[0], 512);
        check("t5_period_max", mx_p[0], 512);
        check("t5_ch1_busy", busy[1], 0);

        check("pulse_hi_min", hi_min, STEP_HI);
        check("pulse_hi_max", hi_max, STEP_HI);
        check("dir_stable", dir_viol, 0);

        // Test 6: reset during a step pulse
        wait_rises(0, 1, 1200, "t6_pulse");
        cyc_wait(1);
        check("t6_mid_pulse", step[0], 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t6_step", step, 0);
        check("t6_pos0", position[0], 0);
        check("t6_en_n", en_n, 1);
        check("t6_cmd_ready", cmd_if.cmd_ready, 0);
        check("t6_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
